alu_seq_core: RTL and testbench
===============================

// Module: alu_seq_core
// PURPOSE
//   Parametrised, registered ALU core with an operand handshake. Adds a multi-cycle
//   shift-add multiplier, result/flag registers, an accumulator feedback mode and
//   output backpressure. It sits between the Tiny Tapeout pin wrapper and operand
//   sources.
// PARAMETERS
//   WIDTH   8   operand/result width; power of two, >= 4
//   SHW     $clog2(WIDTH)   shift-amount width (derived, localparam)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      synchronous, active-low reset
//   ena        in   1      design enable; 0 freezes all state
//   in_valid   in   1      operand/op request valid
//   in_ready   out  1      core can accept a request
//   op         in   3      000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
//   acc_mode   in   1      1: operand A := acc register; 0: A := a
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B (SHL/SHR use b[SHW-1:0] only)
//   out_valid  out  1      result/flags valid
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  result (MUL: product low word)
//   result_hi  out  WIDTH  MUL: product high word; 0 for other ops
//   flag_c     out  1      carry / no-borrow / last bit shifted out / product overflow
//   flag_z     out  1      result zero (MUL: full 2*WIDTH product zero)
//   flag_n     out  1      result[WIDTH-1]
//   flag_v     out  1      signed overflow (ADD/SUB only, else 0)
//   busy       out  1      MUL iteration in progress
// BEHAVIOUR
//   - Reset (rst_n=0 at clk edge): state=IDLE. result, result_hi, all flags, acc,
//     out_valid and busy are 0. Reset has priority over ena. It aborts any op,
//     including a MUL in progress.
//   - ena=0: every register holds its value. in_ready is forced to 0. Outputs keep
//     their last values.
//   - FSM states: IDLE, MUL, DONE.
//     - in_ready = ena & (state==IDLE).
//     - Accept occurs when in_valid & in_ready. The core latches op, A (a or acc),
//       and b.
//     - IDLE -> DONE on accept of a non-MUL op. Result and flags are registered at
//       that edge, so out_valid=1 on the following cycle (latency 1).
//     - IDLE -> MUL on accept of MUL. The multiplier runs WIDTH cycles, one
//       shift-add per cycle, with busy=1 during them. Then MUL -> DONE, so
//       out_valid rises WIDTH+1 cycles after accept.
//     - DONE: out_valid=1 and all outputs are stable until out_valid & out_ready.
//       Then DONE -> IDLE: out_valid drops and in_ready=1 on the next cycle. There
//       is no same-cycle accept of a new request while out_valid=1.
//   - acc register: loaded with result (low word) when DONE is entered.
//     acc_mode is sampled only at accept.
//   - Arithmetic is unsigned modulo 2^WIDTH unless stated otherwise.
//     - ADD: {C,R} = A+B. V = (A[msb]==B[msb]) & (R[msb]!=A[msb]).
//     - SUB: R = A-B. C = (A >= B) unsigned, i.e. no borrow.
//       V = (A[msb]!=B[msb]) & (R[msb]!=A[msb]).
//     - AND/OR/XOR: C=0, V=0.
//     - SHL/SHR (logical, zero fill) by s = b[SHW-1:0]. C = last bit shifted out;
//       C=0 if s==0. V=0.
//     - MUL: unsigned {result_hi,result} = A*B. C = (result_hi != 0). V=0.
//       N = result[WIDTH-1].
//   - result_hi = 0 for every non-MUL op.
//   - Z for non-MUL ops is (R==0).
//   - ena dropping during MUL pauses the iteration; the cycle count resumes when
//     ena returns.
// TESTING (WIDTH=8)
//   1. ADD a=F0 b=20 -> 1 cycle after accept: out_valid=1, result=10, C=1, V=0,
//      Z=0, N=0.
//   2. SUB a=80 b=01 -> result=7F, C=1, V=1, N=0.
//      SUB a=50 b=70 -> result=E0, C=0, N=1, V=0.
//   3. MUL a=FF b=FF -> busy=1 for 8 cycles; out_valid exactly 9 cycles after
//      accept; result_hi=FE, result=01, C=1, Z=0.
//      MUL a=00 b=37 -> Z=1, C=0.
//   4. Backpressure: hold out_ready=0 for 5 cycles after result -> result/flags
//      stable, in_ready=0. Then out_ready=1 for one cycle -> out_valid=0 and
//      in_ready=1 next cycle.
//   5. Accumulator: ADD a=03 b=04 -> 07. Then acc_mode=1 ADD b=05 -> 0C.
//      Then SHL acc_mode=1 b=04 -> C0, C=0.
//   6. Reset mid-MUL: rst_n=0 on cycle 4 of MUL -> next cycle out_valid=0, busy=0,
//      result=0, acc=0, in_ready=1 once rst_n=1.
//      Also: ena=0 for 3 cycles mid-MUL -> out_valid delayed by exactly 3 cycles.

Source files
------------

// File: rtl/alu_seq_core.sv
// Registered ALU core with an operand handshake, a shift-add multiplier,
// an accumulator feedback path and output backpressure.
module alu_seq_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic             acc_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   typedef struct packed {
      logic [WIDTH-1:0] lo;
      logic [WIDTH-1:0] hi;
      logic             c;
      logic             z;
      logic             n;
      logic             v;
   } rsp_t;

   logic [1:0]         state_q, state_d;
   rsp_t               rsp_q, rsp_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [SHW-1:0]     cnt_q, cnt_d;

   logic               accept;
   logic [WIDTH-1:0]   opa;
   logic [SHW-1:0]     shamt;
   logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w;
   logic [WIDTH-1:0]   alu_r;
   logic               alu_c, alu_v;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   assign in_ready  = ena & (state_q == S_IDLE);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_MUL);

   assign result    = rsp_q.lo;
   assign result_hi = rsp_q.hi;
   assign flag_c    = rsp_q.c;
   assign flag_z    = rsp_q.z;
   assign flag_n    = rsp_q.n;
   assign flag_v    = rsp_q.v;

   // Single-cycle datapath; the carry of each op lands in the extra top/bottom bit.
   always_comb begin
      opa   = acc_mode ? acc_q : a;
      shamt = b[SHW-1:0];
      add_w = {1'b0, opa} + {1'b0, b};
      sub_w = {1'b0, opa} - {1'b0, b};
      shl_w = {1'b0, opa} << shamt;
      shr_w = {opa, 1'b0} >> shamt;
      alu_r = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (op)
         OP_ADD: begin
            alu_r = add_w[WIDTH-1:0];
            alu_c = add_w[WIDTH];
            alu_v = (opa[MSB] == b[MSB]) & (alu_r[MSB] != opa[MSB]);
         end
         OP_SUB: begin
            alu_r = sub_w[WIDTH-1:0];
            alu_c = ~sub_w[WIDTH];
            alu_v = (opa[MSB] != b[MSB]) & (alu_r[MSB] != opa[MSB]);
         end
         OP_AND: alu_r = opa & b;
         OP_OR:  alu_r = opa | b;
         OP_XOR: alu_r = opa ^ b;
         OP_SHL: begin
            alu_r = shl_w[WIDTH-1:0];
            alu_c = shl_w[WIDTH];
         end
         OP_SHR: begin
            alu_r = shr_w[WIDTH:1];
            alu_c = shr_w[0];
         end
         default: ;
      endcase
   end

   // One shift-add step: the low half holds the remaining multiplier bits.
   always_comb begin
      mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      mul_next = {mul_sum, prod_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d = state_q;
      rsp_d   = rsp_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (op == OP_MUL) begin
                  mcand_d = opa;
                  prod_d  = {{WIDTH{1'b0}}, b};
                  cnt_d   = '0;
                  state_d = S_MUL;
               end else begin
                  rsp_d.lo = alu_r;
                  rsp_d.hi = '0;
                  rsp_d.c  = alu_c;
                  rsp_d.z  = (alu_r == '0);
                  rsp_d.n  = alu_r[MSB];
                  rsp_d.v  = alu_v;
                  acc_d    = alu_r;
                  state_d  = S_DONE;
               end
            end
         end
         S_MUL: begin
            prod_d = mul_next;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               rsp_d.lo = mul_next[WIDTH-1:0];
               rsp_d.hi = mul_next[2*WIDTH-1:WIDTH];
               rsp_d.c  = (mul_next[2*WIDTH-1:WIDTH] != '0);
               rsp_d.z  = (mul_next == '0);
               rsp_d.n  = mul_next[MSB];
               rsp_d.v  = 1'b0;
               acc_d    = mul_next[WIDTH-1:0];
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rsp_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
      end else if (ena) begin
         state_q <= state_d;
         rsp_q   <= rsp_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_seq_core.sv
// Randomised and directed checks of alu_seq_core against an integer-arithmetic model.
module tb_alu_seq_core;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ena = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   op = '0;
   logic         acc_mode = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result, result_hi;
   logic         flag_c, flag_z, flag_n, flag_v, busy;
   logic [3:0]   flags;

   int n_err = 0;
   int n_chk = 0;
   int acc_m = 0;

   assign flags = {flag_c, flag_z, flag_n, flag_v};

   always #5 clk = ~clk;

   alu_seq_core #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .acc_mode(acc_mode), .a(a), .b(b), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .result_hi(result_hi),
      .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on 8-bit operands.
   function automatic void model(input int o, input int x, input int y,
                                 output int r, output int hi, output int c,
                                 output int z, output int n, output int v);
      int s, sx, sy, sr, p;
      sx = (x >= 128) ? x - 256 : x;
      sy = (y >= 128) ? y - 256 : y;
      hi = 0; c = 0; v = 0; r = 0;
      case (o)
         0: begin s = x + y; r = s % 256; c = (s > 255) ? 1 : 0;
                  sr = sx + sy; v = (sr > 127 || sr < -128) ? 1 : 0; end
         1: begin r = (x - y + 256) % 256; c = (x >= y) ? 1 : 0;
                  sr = sx - sy; v = (sr > 127 || sr < -128) ? 1 : 0; end
         2: r = x & y;
         3: r = x | y;
         4: r = x ^ y;
         5: begin s = y % 8; r = (x << s) % 256; c = (s == 0) ? 0 : ((x >> (8 - s)) & 1); end
         6: begin s = y % 8; r = x >> s; c = (s == 0) ? 0 : ((x >> (s - 1)) & 1); end
         default: begin p = x * y; r = p % 256; hi = p / 256; c = (hi != 0) ? 1 : 0; end
      endcase
      z = (r == 0 && hi == 0) ? 1 : 0;
      n = (r >> 7) & 1;
   endfunction

   task automatic run_op(input int o, input int am, input int av, input int bv,
                         input int hold, input int pause);
      int A, er, ehi, ec, ez, en, ev, lat, bcnt, pleft, guard;
      logic [W-1:0] r0, h0;
      logic [3:0]   f0;
      A = (am != 0) ? acc_m : av;
      model(o, A, bv, er, ehi, ec, ez, en, ev);
      guard = 0;
      while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
      check("in_ready_idle", in_ready, 1);
      in_valid = 1'b1; op = o[2:0]; acc_mode = am[0]; a = av[W-1:0]; b = bv[W-1:0];
      @(negedge clk);
      in_valid = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
      acc_mode = 1'($urandom);
      lat = 1; bcnt = 0; pleft = pause;
      while (!out_valid && lat < 40) begin
         if (busy) bcnt++;
         if (lat >= 3 && pleft > 0) begin ena = 1'b0; pleft--; end
         else ena = 1'b1;
         @(negedge clk);
         lat++;
      end
      ena = 1'b1;
      check("latency", lat, (o == 7) ? 9 + pause : 1);
      if (o == 7) check("busy_cycles", bcnt, 8 + pause);
      check("result", result, er);
      check("result_hi", result_hi, ehi);
      check("flags_cznv", flags, {ec[0], ez[0], en[0], ev[0]});
      acc_m = er;
      r0 = result; h0 = result_hi; f0 = flags;
      for (int k = 0; k < hold; k++) begin
         check("in_ready_done", in_ready, 0);
         @(negedge clk);
         check("hold_stable", {out_valid, result, result_hi, flags}, {1'b1, r0, h0, f0});
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("release_valid", out_valid, 0);
      check("release_ready", in_ready, 1);
   endtask

   initial begin
      int o, hold, pause;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_outputs", {out_valid, busy, result, result_hi, flags}, '0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);

      run_op(0, 0, 'hF0, 'h20, 0, 0);
      check("spec_add", {result, flags}, {8'h10, 4'b1000});
      run_op(1, 0, 'h80, 'h01, 0, 0);
      check("spec_sub1", {result, flag_c, flag_n, flag_v}, {8'h7F, 3'b101});
      run_op(1, 0, 'h50, 'h70, 0, 0);
      check("spec_sub2", {result, flag_c, flag_n, flag_v}, {8'hE0, 3'b010});
      run_op(7, 0, 'hFF, 'hFF, 0, 0);
      check("spec_mul", {result_hi, result, flag_c, flag_z}, {8'hFE, 8'h01, 2'b10});
      run_op(7, 0, 'h00, 'h37, 0, 0);
      check("spec_mul0", {flag_c, flag_z}, 2'b01);
      run_op(0, 0, 'h12, 'h34, 5, 0);
      run_op(0, 0, 'h03, 'h04, 0, 0);
      run_op(0, 1, 'h00, 'h05, 0, 0);
      check("spec_acc_add", result, 8'h0C);
      run_op(5, 1, 'h00, 'h04, 0, 0);
      check("spec_acc_shl", {result, flag_c}, {8'hC0, 1'b0});
      run_op(7, 0, 'h5A, 'h3C, 1, 3);

      // Reset on the fourth MUL cycle.
      @(negedge clk);
      in_valid = 1'b1; op = 3'b111; acc_mode = 1'b0; a = 8'hFF; b = 8'hFF;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midmul_rst", {out_valid, busy, result, result_hi, flags}, '0);
      rst_n = 1'b1;
      @(negedge clk);
      check("midmul_ready", {in_ready, out_valid}, 2'b10);
      acc_m = 0;
      run_op(0, 1, 'hAA, 'h00, 0, 0);

      for (int i = 0; i < 150; i++) begin
         o = $urandom_range(0, 7);
         hold = $urandom_range(0, 2);
         pause = (o == 7) ? $urandom_range(0, 2) : 0;
         run_op(o, $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255),
                hold, pause);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
